bf_truth_table_scanner: RTL and testbench
=========================================

# bf_truth_table_scanner

Sequential stimulus-and-capture stage wrapped around a 3-input combinational Boolean function cell. It walks the function's inputs {A,B,C} through all eight codes and lets the outputs settle before sampling Y at each code. It builds the 8-bit truth table, compares it against a reference mask, and reports pass/fail, so the function cell can be characterised in-system rather than only from a bench.

## Interface
Parameters:
- SETTLE_CYCLES, default 2: clock cycles {A,B,C} is held before Y is sampled. Legal range 1..15. A 4-bit settle counter is sufficient.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst_n  input  1  asynchronous, active-low reset; releases synchronously to clk.
- start  input  1  scan request; sampled only in IDLE.
- expected  input  8  reference truth table; bit i is the expected Y for {A,B,C}=i. Latched on start acceptance.
- Y  input  1  output of the function cell under scan.
- A, B, C  output  1 each  registered drive to the function cell; {A,B,C} equals the current index.
- busy  output  1  high from start acceptance until DONE is entered.
- done  output  1  high from DONE entry until the next start acceptance.
- pass  output  1  valid while done=1; 1 iff mismatch==0.
- truth  output  8  captured truth table; bit i is Y sampled at index i.
- mismatch  output  8  bit i = truth[i] XOR expected_latched[i].

## Operation
- State machine: IDLE, SETTLE, SAMPLE, DONE. Registered 3-bit index idx and settle counter cnt.
- Reset (async, rst_n=0):
  - state=IDLE, idx=0, cnt=0.
  - A=B=C=0, busy=0, done=0, pass=0, truth=0, mismatch=0, expected_latched=0.
- IDLE:
  - start=0: hold all outputs; done, pass, truth and mismatch keep their last values.
  - start=1: accept. Set idx=0, cnt=0, truth=0, mismatch=0, done=0, pass=0, busy=1, expected_latched=expected. Go to SETTLE.
- SETTLE:
  - {A,B,C}=idx throughout; cnt increments each cycle.
  - When cnt==SETTLE_CYCLES-1, go to SAMPLE. SETTLE therefore lasts exactly SETTLE_CYCLES cycles.
- SAMPLE (one cycle):
  - {A,B,C} unchanged.
  - At the rising edge ending this cycle: truth[idx]=Y, mismatch[idx]=Y^expected_latched[idx].
  - idx<7: idx=idx+1, cnt=0, go to SETTLE.
  - idx==7: go to DONE; idx wraps to 0.
- DONE (one cycle):
  - busy=0, done=1, pass=(mismatch==0), A=B=C=0.
  - Next state is IDLE.
- start while busy=1 or in DONE is ignored; it is not queued.
- Changes on expected during a scan have no effect.
- Y is used only in SAMPLE; glitches on Y in SETTLE are ignored.

## Timing
- Each vector occupies SETTLE_CYCLES+1 cycles. A full scan is 8*(SETTLE_CYCLES+1) cycles from start acceptance to DONE entry; with the default that is 24.
- {A,B,C} changes only on the edge that enters SETTLE from SAMPLE or IDLE. It returns to 0 on DONE entry.
- truth and mismatch bits update one at a time, at the end of each SAMPLE cycle, in ascending index order.
- done and pass rise together, on the edge entering DONE. They stay high until the edge that accepts the next start.
- Back-to-back scans: start held high through DONE is accepted in the first IDLE cycle, one cycle after DONE.
- Reset asserted mid-scan clears everything immediately, with no completion.

## Test plan
- Reset, then idle with start=0 for 10 cycles: all outputs 0, A=B=C=0, busy=0.
- Majority-function cell with expected=8'b1110_1000 and a start pulse: busy high for 24 cycles, then truth=8'hE8, mismatch=0, done=1, pass=1.
- Same cell with expected=8'hE9: truth=8'hE8, mismatch=8'h01, pass=0.
- Log {A,B,C} every cycle during a scan: the sequence is 0..7, each value held exactly 3 cycles (SETTLE_CYCLES=2). With SETTLE_CYCLES=1, each value is held 2 cycles and the scan totals 16.
- Pulse start and change expected mid-scan: the scan is not restarted, busy stays high, and the result reflects the expected value latched at the original start.
- Drop rst_n while idx=4: all outputs go to 0 asynchronously. A fresh start afterwards completes a normal scan.

Source files
------------

// File: rtl/bf_truth_table_scanner_if.sv
// Bus between the truth-table scanner and whoever launches scans and provides the
// function cell under test.
interface bf_truth_table_scanner_if;
  logic       start;
  logic [7:0] expected;
  logic       Y;
  logic       A;
  logic       B;
  logic       C;
  logic       busy;
  logic       done;
  logic       pass;
  logic [7:0] truth;
  logic [7:0] mismatch;

  modport master (
    output start, expected, Y,
    input  A, B, C, busy, done, pass, truth, mismatch
  );

  modport slave (
    input  start, expected, Y,
    output A, B, C, busy, done, pass, truth, mismatch
  );
endinterface

// File: rtl/bf_truth_table_scanner.sv
// Scanner that steps a 3-input function cell through all eight input codes.
// At each code it samples Y after a settle delay, then compares the truth table against a latched reference.
module bf_truth_table_scanner #(
  parameter int unsigned SETTLE_CYCLES = 2
) (
  input logic                     clk,
  input logic                     rst_n,
  bf_truth_table_scanner_if.slave bus
);

  typedef enum logic [1:0] {IDLE, SETTLE, SAMPLE, DONE} state_t;

  localparam logic [3:0] CNT_LAST = 4'(SETTLE_CYCLES - 1);

  state_t     state_q, state_d;
  logic [2:0] idx_q, idx_d;
  logic [3:0] cnt_q, cnt_d;
  logic [7:0] truth_q, truth_d;
  logic [7:0] mism_q, mism_d;
  logic [7:0] exp_q, exp_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic       pass_q, pass_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      cnt_q   <= '0;
      truth_q <= '0;
      mism_q  <= '0;
      exp_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      truth_q <= truth_d;
      mism_q  <= mism_d;
      exp_q   <= exp_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    truth_d = truth_q;
    mism_d  = mism_q;
    exp_d   = exp_q;
    busy_d  = busy_q;
    done_d  = done_q;
    pass_d  = pass_q;

    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          idx_d   = '0;
          cnt_d   = '0;
          truth_d = '0;
          mism_d  = '0;
          exp_d   = bus.expected;
          busy_d  = 1'b1;
          done_d  = 1'b0;
          pass_d  = 1'b0;
          state_d = SETTLE;
        end
      end

      SETTLE: begin
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == CNT_LAST) begin
          state_d = SAMPLE;
        end
      end

      SAMPLE: begin
        truth_d[idx_q] = bus.Y;
        mism_d[idx_q]  = bus.Y ^ exp_q[idx_q];
        if (idx_q == 3'd7) begin
          // pass must include the final bit, so it is taken from the next-state mismatch
          idx_d   = '0;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          pass_d  = (mism_d == '0);
          state_d = DONE;
        end else begin
          idx_d   = idx_q + 3'd1;
          cnt_d   = '0;
          state_d = SETTLE;
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  // idx is zero outside a scan, so it doubles as the cell drive
  assign bus.A        = idx_q[2];
  assign bus.B        = idx_q[1];
  assign bus.C        = idx_q[0];
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.pass     = pass_q;
  assign bus.truth    = truth_q;
  assign bus.mismatch = mism_q;

endmodule

// File: tb/tb_bf_truth_table_scanner.sv
// Directed bench for bf_truth_table_scanner driving a majority-function cell,
// with one instance at the default settle time and one at SETTLE_CYCLES=1.
module tb_bf_truth_table_scanner;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  bf_truth_table_scanner_if if0 ();
  bf_truth_table_scanner_if if1 ();

  bf_truth_table_scanner dut0 (.clk(clk), .rst_n(rst_n), .bus(if0));
  bf_truth_table_scanner #(.SETTLE_CYCLES(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(if1));

  // Majority cell: truth table 8'hE8
  assign if0.Y = (if0.A & if0.B) | (if0.A & if0.C) | (if0.B & if0.C);
  assign if1.Y = (if1.A & if1.B) | (if1.A & if1.C) | (if1.B & if1.C);

  // {busy, done, pass, A, B, C, truth, mismatch}
  logic [21:0] st0, st1;
  assign st0 = {if0.busy, if0.done, if0.pass, if0.A, if0.B, if0.C, if0.truth, if0.mismatch};
  assign st1 = {if1.busy, if1.done, if1.pass, if1.A, if1.B, if1.C, if1.truth, if1.mismatch};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
      else begin
        errors++;
        $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
  endtask

  task automatic run_scan(input bit sel, input logic [7:0] exp, input int unsigned hold,
                          input bit disturb, output int busy_n, output int seq_bad,
                          output logic [21:0] first_st);
    logic       b;
    logic [2:0] abc;
    busy_n       = 0;
    seq_bad      = 0;
    if0.expected = exp;
    if1.expected = exp;
    if (sel) if1.start = 1'b1;
    else     if0.start = 1'b1;
    @(posedge clk); #1;
    if0.start = 1'b0;
    if1.start = 1'b0;
    first_st  = sel ? st1 : st0;
    for (int k = 0; k < 200; k++) begin
      b   = sel ? if1.busy : if0.busy;
      abc = sel ? {if1.A, if1.B, if1.C} : {if0.A, if0.B, if0.C};
      if (!b) break;
      if (abc !== 3'(busy_n / int'(hold))) seq_bad++;
      busy_n++;
      if (disturb && busy_n == 5) begin
        if0.start    = 1'b1;
        if0.expected = 8'hE8;
      end
      if (disturb && busy_n == 6) if0.start = 1'b0;
      @(posedge clk); #1;
    end
  endtask

  initial begin
    int          bn;
    int          sb;
    logic [21:0] fs;
    logic        hit;
    checks       = 0;
    errors       = 0;
    rst_n        = 1'b0;
    if0.start    = 1'b0;
    if1.start    = 1'b0;
    if0.expected = 8'h00;
    if1.expected = 8'h00;

    #2;
    check("reset_dut0", 32'(st0), 32'h0);
    check("reset_dut1", 32'(st1), 32'h0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    check("idle_dut0", 32'(st0), 32'h0);
    check("idle_dut1", 32'(st1), 32'h0);

    // Scan 1: matching reference
    run_scan(1'b0, 8'hE8, 3, 1'b0, bn, sb, fs);
    check("scan1_accept", 32'(fs), 32'({1'b1, 1'b0, 1'b0, 3'b000, 8'h00, 8'h00}));
    check("scan1_busy_cycles", 32'(bn), 32'd24);
    check("scan1_abc_sequence", 32'(sb), 32'd0);
    check("scan1_result", 32'(st0), 32'({1'b0, 1'b1, 1'b1, 3'b000, 8'hE8, 8'h00}));
    @(posedge clk); #1;
    check("scan1_done_holds", 32'(st0), 32'({1'b0, 1'b1, 1'b1, 3'b000, 8'hE8, 8'h00}));

    // Scan 2: reference differs in bit 0
    run_scan(1'b0, 8'hE9, 3, 1'b0, bn, sb, fs);
    check("scan2_accept_clears", 32'(fs), 32'({1'b1, 1'b0, 1'b0, 3'b000, 8'h00, 8'h00}));
    check("scan2_busy_cycles", 32'(bn), 32'd24);
    check("scan2_result", 32'(st0), 32'({1'b0, 1'b1, 1'b0, 3'b000, 8'hE8, 8'h01}));

    // SETTLE_CYCLES=1 instance
    run_scan(1'b1, 8'hE8, 2, 1'b0, bn, sb, fs);
    check("s1_busy_cycles", 32'(bn), 32'd16);
    check("s1_abc_sequence", 32'(sb), 32'd0);
    check("s1_result", 32'(st1), 32'({1'b0, 1'b1, 1'b1, 3'b000, 8'hE8, 8'h00}));

    // start and expected disturbed mid-scan
    run_scan(1'b0, 8'hE9, 3, 1'b1, bn, sb, fs);
    check("disturb_busy_cycles", 32'(bn), 32'd24);
    check("disturb_abc_sequence", 32'(sb), 32'd0);
    check("disturb_result", 32'(st0), 32'({1'b0, 1'b1, 1'b0, 3'b000, 8'hE8, 8'h01}));
    repeat (2) @(posedge clk);
    #1;

    // Reset while idx=4
    if0.expected = 8'hE8;
    if0.start    = 1'b1;
    @(posedge clk); #1;
    if0.start = 1'b0;
    hit       = 1'b0;
    for (int k = 0; k < 100; k++) begin
      if ({if0.A, if0.B, if0.C} == 3'd4) begin
        hit = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
    check("reach_idx4", 32'(hit), 32'd1);
    rst_n = 1'b0;
    #1;
    check("async_reset_midscan", 32'(st0), 32'h0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    run_scan(1'b0, 8'hE8, 3, 1'b0, bn, sb, fs);
    check("post_reset_busy_cycles", 32'(bn), 32'd24);
    check("post_reset_result", 32'(st0), 32'({1'b0, 1'b1, 1'b1, 3'b000, 8'hE8, 8'h00}));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
